eeprom_i2c_master: RTL and testbench

Synthesizable I2C master that performs single-byte random writes and random reads on a 2 Kbyte AT24C16-class serial EEPROM over the `scl`/`sda` bus. It sits between the system-side logic, which issues byte requests, and the EEPROM behavioural model on the board-level bench. It generates the bus clock, START/repeated-START/STOP conditions, control and address bytes, and checks ACKs. It returns read data with a one-cycle completion pulse.

---
 rtl/eeprom_i2c_master.sv | 243 ++++++++++++++++++++++++
 tb/tb_eeprom_i2c_master.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eeprom_i2c_master.sv
// Single-byte random write / random read I2C master for a 2 Kbyte AT24C16-class EEPROM.
// Each bus bit is four quarters of QUARTER clocks. scl is push-pull and sda is open-drain.
module eeprom_i2c_master #(
    parameter int QUARTER = 125
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_req,
    input  logic        rd_req,
    input  logic [10:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic        done,
    output logic        ack_err,
    output logic        scl,
    inout  wire         sda
);

    localparam int QW = $clog2(QUARTER);
    localparam logic [QW-1:0] Q_LAST = QW'(QUARTER - 1);

    typedef enum logic [3:0] {
        IDLE,
        START,
        TX_BYTE,
        RX_ACK,
        RESTART,
        RX_BYTE,
        TX_NACK,
        STOP,
        DONE
    } state_t;

    state_t        state;
    logic [QW-1:0] q_cnt;
    logic [1:0]    phase;
    logic [3:0]    bit_cnt;
    logic [1:0]    byte_idx;
    logic          is_read;
    logic [10:0]   addr_r;
    logic [7:0]    wdata_r;
    logic [7:0]    tx_sh;
    logic [7:0]    rx_sh;
    logic          nack;
    logic          sda_oe;
    logic          sda_meta;
    logic          sda_in;
    logic          quarter_end;

    function automatic logic [7:0] ctrl_byte(input logic [10:0] a, input logic rw);
        return {4'b1010, a[10:8], rw};
    endfunction

    assign sda         = sda_oe ? 1'b0 : 1'bz;
    assign quarter_end = (q_cnt == Q_LAST);

    // sda comes from another clock domain; only the slave moves it while scl is low,
    // so two clocks of synchronizer latency stay well inside the sampling quarter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_meta <= 1'b1;
            sda_in   <= 1'b1;
        end else begin
            sda_meta <= sda;
            sda_in   <= sda_meta;
        end
    end

    // NOTE: every register here uses <= so all branches see the values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            q_cnt    <= '0;
            phase    <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            is_read  <= 1'b0;
            addr_r   <= '0;
            wdata_r  <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            nack     <= 1'b0;
            scl      <= 1'b1;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ack_err  <= 1'b0;
            rdata    <= '0;
        end else begin
            done <= 1'b0;

            if (state == IDLE || state == DONE || quarter_end) begin
                q_cnt <= '0;
            end else begin
                q_cnt <= q_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (wr_req || rd_req) begin
                        is_read  <= !wr_req;
                        addr_r   <= addr;
                        wdata_r  <= wdata;
                        tx_sh    <= ctrl_byte(addr, 1'b0);
                        byte_idx <= '0;
                        bit_cnt  <= '0;
                        phase    <= '0;
                        nack     <= 1'b0;
                        busy     <= 1'b1;
                        ack_err  <= 1'b0;
                        state    <= START;
                    end
                end

                START: begin
                    if (quarter_end) begin
                        if (phase == 2'd0) begin
                            phase  <= 2'd1;
                            sda_oe <= 1'b1;
                        end else begin
                            phase  <= 2'd0;
                            scl    <= 1'b0;
                            sda_oe <= ~tx_sh[7];
                            state  <= TX_BYTE;
                        end
                    end
                end

                DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    ack_err <= nack;
                    if (is_read && !nack) begin
                        rdata <= rx_sh;
                    end
                    state <= IDLE;
                end

                default: begin
                    // Four-quarter bit cells: scl low for Q0/Q1, high for Q2/Q3.
                    if (quarter_end) begin
                        if (phase != 2'd3) begin
                            phase <= phase + 1'b1;
                            if (phase == 2'd1) begin
                                scl <= 1'b1;
                            end
                            if (phase == 2'd2) begin
                                if (state == RESTART) sda_oe <= 1'b1;
                                if (state == STOP)    sda_oe <= 1'b0;
                                if (state == RX_ACK && sda_in) nack <= 1'b1;
                                if (state == RX_BYTE) rx_sh <= {rx_sh[6:0], sda_in};
                            end
                        end else begin
                            phase <= 2'd0;
                            scl   <= 1'b0;
                            case (state)
                                TX_BYTE: begin
                                    if (bit_cnt == 4'd7) begin
                                        bit_cnt <= '0;
                                        sda_oe  <= 1'b0;
                                        state   <= RX_ACK;
                                    end else begin
                                        bit_cnt <= bit_cnt + 1'b1;
                                        tx_sh   <= {tx_sh[6:0], 1'b0};
                                        sda_oe  <= ~tx_sh[6];
                                    end
                                end

                                RX_ACK: begin
                                    if (nack) begin
                                        sda_oe <= 1'b1;
                                        state  <= STOP;
                                    end else begin
                                        case (byte_idx)
                                            2'd0: begin
                                                byte_idx <= 2'd1;
                                                tx_sh    <= addr_r[7:0];
                                                sda_oe   <= ~addr_r[7];
                                                state    <= TX_BYTE;
                                            end
                                            2'd1: begin
                                                byte_idx <= 2'd2;
                                                if (is_read) begin
                                                    sda_oe <= 1'b0;
                                                    state  <= RESTART;
                                                end else begin
                                                    tx_sh  <= wdata_r;
                                                    sda_oe <= ~wdata_r[7];
                                                    state  <= TX_BYTE;
                                                end
                                            end
                                            default: begin
                                                if (is_read) begin
                                                    sda_oe <= 1'b0;
                                                    state  <= RX_BYTE;
                                                end else begin
                                                    sda_oe <= 1'b1;
                                                    state  <= STOP;
                                                end
                                            end
                                        endcase
                                    end
                                end

                                RESTART: begin
                                    // Control bytes always start with a 1, so sda stays released.
                                    tx_sh  <= ctrl_byte(addr_r, 1'b1);
                                    sda_oe <= 1'b0;
                                    state  <= TX_BYTE;
                                end

                                RX_BYTE: begin
                                    if (bit_cnt == 4'd7) begin
                                        bit_cnt <= '0;
                                        state   <= TX_NACK;
                                    end else begin
                                        bit_cnt <= bit_cnt + 1'b1;
                                    end
                                end

                                TX_NACK: begin
                                    sda_oe <= 1'b1;
                                    state  <= STOP;
                                end

                                STOP: begin
                                    scl   <= 1'b1;
                                    state <= DONE;
                                end

                                default: begin
                                    state <= IDLE;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eeprom_i2c_master.sv
// Self-checking bench: clocked EEPROM slave on the bus plus a byte-level reference
// memory and closed-form transaction lengths.
module tb_eeprom_i2c_master;

    localparam int Q       = 4;
    localparam int TIMEOUT = 2000;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        wr_req = 1'b0;
    logic        rd_req = 1'b0;
    logic [10:0] addr   = '0;
    logic [7:0]  wdata  = '0;
    logic [7:0]  rdata;
    logic        busy;
    logic        done;
    logic        ack_err;
    logic        scl;
    wire         sda;

    always #5 clk = ~clk;

    eeprom_i2c_master #(.QUARTER(Q)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_req  (wr_req),
        .rd_req  (rd_req),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .busy    (busy),
        .done    (done),
        .ack_err (ack_err),
        .scl     (scl),
        .sda     (sda)
    );

    // ---------------- EEPROM slave model ----------------
    typedef enum logic [2:0] {S_IDLE, S_RX, S_ACK, S_TX, S_MACK} slv_t;

    logic       slv_drive;
    logic       slv_en   = 1'b1;
    logic       slv_rst  = 1'b1;
    logic       mem_init = 1'b1;
    logic [7:0] mem_seed = 8'h00;
    logic [7:0] mem [2048];
    logic [7:0] rx_bytes [$];
    slv_t       sp;
    logic       scl_q, sda_q, rw, mack_bit;
    logic [3:0] cnt;
    logic [1:0] bidx;
    logic [7:0] sh, tx, ptr_lo;
    logic [2:0] page;
    int         stop_cnt = 0;

    pullup (sda);
    assign sda = slv_drive ? 1'b0 : 1'bz;

    function automatic logic [7:0] init_val(input int i);
        return 8'(i * 37) ^ mem_seed;
    endfunction

    always @(negedge clk) begin
        scl_q <= scl;
        sda_q <= sda;
        if (mem_init) begin
            for (int i = 0; i < 2048; i++) mem[i] <= init_val(i);
        end
        if (slv_rst) begin
            sp        <= S_IDLE;
            slv_drive <= 1'b0;
            cnt       <= '0;
            bidx      <= '0;
            mack_bit  <= 1'b0;
        end else if (scl_q && scl && sda_q && !sda) begin
            sp        <= S_RX;
            cnt       <= '0;
            bidx      <= '0;
            slv_drive <= 1'b0;
        end else if (scl_q && scl && !sda_q && sda) begin
            sp        <= S_IDLE;
            slv_drive <= 1'b0;
            stop_cnt  <= stop_cnt + 1;
        end else if (!scl_q && scl) begin
            if (sp == S_RX) begin
                sh  <= {sh[6:0], sda};
                cnt <= cnt + 1'b1;
            end else if (sp == S_MACK) begin
                mack_bit <= sda;
                sp       <= S_IDLE;
            end
        end else if (scl_q && !scl) begin
            case (sp)
                S_RX: begin
                    if (cnt == 4'd8) begin
                        rx_bytes.push_back(sh);
                        if (bidx == 2'd0) begin
                            rw   <= sh[0];
                            page <= sh[3:1];
                        end else if (bidx == 2'd1) begin
                            ptr_lo <= sh;
                        end else begin
                            mem[{page, ptr_lo}] <= sh;
                        end
                        bidx      <= bidx + 1'b1;
                        slv_drive <= slv_en;
                        sp        <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (rw && bidx == 2'd1) begin
                        tx        <= {mem[{page, ptr_lo}][6:0], 1'b0};
                        slv_drive <= slv_en & ~mem[{page, ptr_lo}][7];
                        cnt       <= 4'd1;
                        sp        <= S_TX;
                    end else begin
                        slv_drive <= 1'b0;
                        cnt       <= '0;
                        sp        <= S_RX;
                    end
                end
                S_TX: begin
                    if (cnt == 4'd8) begin
                        slv_drive <= 1'b0;
                        sp        <= S_MACK;
                    end else begin
                        slv_drive <= slv_en & ~tx[7];
                        tx        <= {tx[6:0], 1'b0};
                        cnt       <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- reference model and checking ----------------
    logic [7:0] ref_mem [2048];
    logic [7:0] exp_rdata;
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transaction length in clocks from accept edge to the edge that raises done.
    function automatic int exp_clocks(input bit rd, input int abort_after);
        int quarters;
        if (abort_after == 0) quarters = rd ? (2 + 18*4 + 4 + 18*4 + 4) : (2 + 27*4 + 4);
        else quarters = 2 + 9*abort_after*4 + 4 + ((rd && abort_after == 3) ? 4 : 0);
        return quarters * Q + 1;
    endfunction

    function automatic logic [7:0] byte_at(input int i);
        if (i < rx_bytes.size()) return rx_bytes[i];
        return 8'hxx;
    endfunction

    task automatic txn(input string tag, input logic w, input logic r, input logic [10:0] a,
                       input logic [7:0] d, input bit acked, input int poke_at);
        int   base, stops, lat;
        bit   is_rd;
        logic [7:0] ctrl_w;
        is_rd  = !w;
        ctrl_w = {4'b1010, a[10:8], 1'b0};
        base   = rx_bytes.size();
        stops  = stop_cnt;
        @(negedge clk);
        wr_req = w;
        rd_req = r;
        addr   = a;
        wdata  = d;
        @(posedge clk);
        #1;
        check({tag, ":busy_rise"}, busy, 1'b1);
        check({tag, ":ack_err_clr"}, ack_err, 1'b0);
        @(negedge clk);
        wr_req = 1'b0;
        rd_req = 1'b0;
        lat = 0;
        while (1) begin
            @(posedge clk);
            lat++;
            #1;
            rd_req = (lat == poke_at);
            if (done) break;
            if (lat > TIMEOUT) begin
                check({tag, ":done_timeout"}, done, 1'b1);
                break;
            end
        end
        rd_req = 1'b0;
        check({tag, ":latency"}, lat, exp_clocks(is_rd, acked ? 0 : 1));
        check({tag, ":busy_fall"}, busy, 1'b0);
        check({tag, ":ack_err"}, ack_err, !acked);
        if (acked && !is_rd) ref_mem[a] = d;
        if (acked && is_rd) exp_rdata = ref_mem[a];
        check({tag, ":rdata"}, rdata, exp_rdata);
        @(posedge clk);
        #1;
        check({tag, ":done_pulse"}, done, 1'b0);
        check({tag, ":stops"}, stop_cnt, stops + 1);
        check({tag, ":ctrl_w"}, byte_at(base), ctrl_w);
        if (acked) begin
            check({tag, ":nbytes"}, rx_bytes.size(), base + 3);
            check({tag, ":addr_byte"}, byte_at(base + 1), a[7:0]);
            check({tag, ":third"}, byte_at(base + 2), is_rd ? (ctrl_w | 8'h01) : d);
            if (is_rd) check({tag, ":master_nack"}, mack_bit, 1'b1);
            else       check({tag, ":mem"}, mem[a], ref_mem[a]);
        end else begin
            check({tag, ":nbytes"}, rx_bytes.size(), base + 1);
        end
    endtask

    initial begin
        logic [10:0] a, last_a;
        logic [7:0]  d;
        int          base;

        mem_seed = 8'($urandom);
        for (int i = 0; i < 2048; i++) ref_mem[i] = init_val(i);
        exp_rdata = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check("rst:scl", scl, 1'b1);
        check("rst:sda", sda, 1'b1);
        check("rst:busy", busy, 1'b0);
        check("rst:done", done, 1'b0);
        check("rst:ack_err", ack_err, 1'b0);
        check("rst:rdata", rdata, 8'h00);
        @(posedge clk);
        slv_rst  = 1'b0;
        mem_init = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Directed write then read-back at 0x5A3.
        base = rx_bytes.size();
        txn("wr5a3", 1'b1, 1'b0, 11'h5A3, 8'h3C, 1'b1, 0);
        check("wr5a3:ctrl_lit", byte_at(base), 8'hAA);
        check("wr5a3:addr_lit", byte_at(base + 1), 8'hA3);
        check("wr5a3:mem_lit", mem[11'h5A3], 8'h3C);
        base = rx_bytes.size();
        txn("rd5a3", 1'b0, 1'b1, 11'h5A3, 8'h00, 1'b1, 0);
        check("rd5a3:ctrl_r_lit", byte_at(base + 2), 8'hAB);
        check("rd5a3:rdata_lit", rdata, 8'h3C);

        // Both ends of the address space.
        txn("wr000", 1'b1, 1'b0, 11'h000, 8'hFF, 1'b1, 0);
        txn("wr7ff", 1'b1, 1'b0, 11'h7FF, 8'h01, 1'b1, 0);
        base = rx_bytes.size();
        txn("rd000", 1'b0, 1'b1, 11'h000, 8'h00, 1'b1, 0);
        check("rd000:ctrl_lit", byte_at(base), 8'hA0);
        check("rd000:rdata_lit", rdata, 8'hFF);
        base = rx_bytes.size();
        txn("rd7ff", 1'b0, 1'b1, 11'h7FF, 8'h00, 1'b1, 0);
        check("rd7ff:ctrl_lit", byte_at(base), 8'hAE);
        check("rd7ff:rdata_lit", rdata, 8'h01);

        // Absent slave: NACK on the control byte, rdata kept, ack_err held until next accept.
        @(posedge clk);
        slv_en = 1'b0;
        txn("noslave", 1'b1, 1'b0, 11'h2C4, 8'h99, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("noslave:ack_err_hold", ack_err, 1'b1);
        check("noslave:mem_kept", mem[11'h2C4], ref_mem[11'h2C4]);
        @(posedge clk);
        slv_en = 1'b1;

        // Both requests high: write wins; rd_req pulsed while busy is ignored.
        txn("both", 1'b1, 1'b1, 11'h3B7, 8'h5E, 1'b1, 100);
        base = rx_bytes.size();
        repeat (8) @(posedge clk);
        #1;
        check("both:still_idle", busy, 1'b0);
        check("both:no_extra", rx_bytes.size(), base);

        // Reset during the address byte of a read.
        @(negedge clk);
        rd_req = 1'b1;
        addr   = 11'h123;
        @(posedge clk);
        @(negedge clk);
        rd_req = 1'b0;
        repeat ((2 + 9*4 + 3*4) * Q) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        exp_rdata = 8'h00;
        check("midrst:scl", scl, 1'b1);
        check("midrst:sda", sda, 1'b1);
        check("midrst:busy", busy, 1'b0);
        check("midrst:rdata", rdata, exp_rdata);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        slv_rst = 1'b1;
        @(posedge clk);
        slv_rst = 1'b0;
        txn("postrst_wr", 1'b1, 1'b0, 11'h456, 8'hC3, 1'b1, 0);
        txn("postrst_rd", 1'b0, 1'b1, 11'h456, 8'h00, 1'b1, 0);

        // Randomized mix against the reference memory.
        last_a = 11'h456;
        for (int n = 0; n < 16; n++) begin
            a = 11'($urandom_range(0, 2047));
            if ($urandom_range(0, 7) == 0) a = $urandom_range(0, 1) ? 11'h7FF : 11'h000;
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                txn("rnd_wr", 1'b1, 1'b0, a, d, 1'b1, 0);
                last_a = a;
            end else begin
                if ($urandom_range(0, 1) == 1) a = last_a;
                txn("rnd_rd", 1'b0, 1'b1, a, 8'h00, 1'b1, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
